max_stream_sched: RTL and testbench

//  Sequences one shared max comparator over a stream of operand words and returns
//  the frame maximum, its position and the frame length.

---
 rtl/max_sched_pkg.sv | 22 ++
 rtl/max_cmp.sv | 27 ++
 rtl/max_stream_sched.sv | 119 +++++++++++
 tb/tb_max_stream_sched.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/max_sched_pkg.sv
// ============================================================================
// Module : max_sched_pkg
// Brief  : Shared state encoding and default sizes for the max stream scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package max_sched_pkg;

    localparam int c_W_DEF       = 8;
    localparam int c_MAX_LEN_DEF = 16;
    localparam int c_IDXW_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/max_cmp.sv
// ============================================================================
// Module : max_cmp
// Brief  : Strict greater-than comparator, the only comparator of the scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module max_cmp #(
    parameter int W      = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt
);

    generate
        if (SIGNED) begin : g_signed
            assign gt = $signed(a) > $signed(b);
        end else begin : g_unsigned
            assign gt = a > b;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/max_stream_sched.sv
// ============================================================================
// Module : max_stream_sched
// Brief  : Reuses one comparator per beat to find a frame's max, index and length.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module max_stream_sched
    import max_sched_pkg::*;
#(
    parameter int W       = c_W_DEF,
    parameter int MAX_LEN = c_MAX_LEN_DEF,
    parameter int IDXW    = c_IDXW_DEF,
    parameter bit SIGNED  = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_max,
    output logic [IDXW-1:0] out_idx,
    output logic [IDXW:0]   out_len,
    output logic            out_ovf
);

    localparam logic [IDXW:0] c_LEN_LIMIT = MAX_LEN[IDXW:0];
    localparam logic [IDXW:0] c_LEN_ONE   = {{IDXW{1'b0}}, 1'b1};

    state_t          r_state_q, w_state_d;
    logic [W-1:0]    r_max_q,   w_max_d;
    logic [IDXW-1:0] r_idx_q,   w_idx_d;
    logic [IDXW:0]   r_len_q,   w_len_d;
    logic            r_ovf_q,   w_ovf_d;
    logic            w_accept;
    logic            w_gt;

    max_cmp #(
        .W      (W),
        .SIGNED (SIGNED)
    ) u_cmp (
        .a  (in_data),
        .b  (r_max_q),
        .gt (w_gt)
    );

    assign in_ready  = (r_state_q != DONE);
    assign out_valid = (r_state_q == DONE);
    assign w_accept  = in_valid & in_ready;

    always_comb begin
        w_state_d = r_state_q;
        w_max_d   = r_max_q;
        w_idx_d   = r_idx_q;
        w_len_d   = r_len_q;
        w_ovf_d   = r_ovf_q;
        case (r_state_q)
            IDLE: begin
                if (w_accept) begin
                    w_max_d   = in_data;
                    w_idx_d   = '0;
                    w_len_d   = c_LEN_ONE;
                    w_ovf_d   = 1'b0;
                    w_state_d = in_last ? DONE : ACC;
                end
            end
            ACC: begin
                if (w_accept) begin
                    // Beats past MAX_LEN only flag overflow; strict > keeps the earliest tie.
                    if (r_len_q < c_LEN_LIMIT) begin
                        if (w_gt) begin
                            w_max_d = in_data;
                            w_idx_d = r_len_q[IDXW-1:0];
                        end
                        w_len_d = r_len_q + c_LEN_ONE;
                    end else begin
                        w_ovf_d = 1'b1;
                    end
                    if (in_last) begin
                        w_state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE;
            r_max_q   <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_ovf_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_max_q   <= w_max_d;
            r_idx_q   <= w_idx_d;
            r_len_q   <= w_len_d;
            r_ovf_q   <= w_ovf_d;
        end
    end

    assign out_max = r_max_q;
    assign out_idx = r_idx_q;
    assign out_len = r_len_q;
    assign out_ovf = r_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_max_stream_sched.sv
// ============================================================================
// Module : tb_max_stream_sched
// Brief  : Drives an unsigned and a signed scheduler with the same frames and
//          compares both against a reference built from the frame contents.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_max_stream_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;
    logic [7:0] in_data;

    logic       rdy_u, vld_u, ovf_u, rdy_s, vld_s, ovf_s;
    logic [7:0] max_u, max_s;
    logic [3:0] idx_u, idx_s;
    logic [4:0] len_u, len_s;

    int tests = 0;
    int fails = 0;
    logic [7:0] frame_q[$];

    always #5 clk = ~clk;

    max_stream_sched #(.W(8), .MAX_LEN(16), .IDXW(4), .SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_u), .in_data(in_data),
        .in_last(in_last), .out_valid(vld_u), .out_ready(out_ready), .out_max(max_u),
        .out_idx(idx_u), .out_len(len_u), .out_ovf(ovf_u)
    );

    max_stream_sched #(.W(8), .MAX_LEN(16), .IDXW(4), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s), .in_data(in_data),
        .in_last(in_last), .out_valid(vld_s), .out_ready(out_ready), .out_max(max_s),
        .out_idx(idx_s), .out_len(len_s), .out_ovf(ovf_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " rdy"},  {rdy_u, rdy_s}, 2'b11);
        check({tag, " vld"},  {vld_u, vld_s}, 2'b00);
        check({tag, " max"},  {max_u, max_s}, 16'h0000);
        check({tag, " idx"},  {idx_u, idx_s}, 8'h00);
        check({tag, " len"},  {len_u, len_s}, 10'h000);
        check({tag, " ovf"},  {ovf_u, ovf_s}, 2'b00);
    endtask

    function automatic int sval(input logic [7:0] v, input bit sgn);
        return sgn ? int'($signed(v)) : int'(v);
    endfunction

    // Reference: scan the first min(n,16) values, strictly larger replaces.
    task automatic model(input bit sgn, output logic [7:0] m, output logic [3:0] ix,
                         output logic [4:0] ln, output logic ov);
        int n;
        int cmp_n;
        n     = frame_q.size();
        cmp_n = (n > 16) ? 16 : n;
        m     = frame_q[0];
        ix    = '0;
        for (int i = 1; i < cmp_n; i++) begin
            if (sval(frame_q[i], sgn) > sval(m, sgn)) begin
                m  = frame_q[i];
                ix = 4'(i);
            end
        end
        ln = 5'(cmp_n);
        ov = (n > 16);
    endtask

    task automatic run_frame(input string tag, input int hold, input bit bubbles);
        logic [7:0] mu, ms;
        logic [3:0] iu, is;
        logic [4:0] lu, ls;
        logic       ou, os;
        int         n;
        n = frame_q.size();
        for (int i = 0; i < n; i++) begin
            if (bubbles && $urandom_range(0, 3) == 0) begin
                in_valid  = 1'b0;
                in_last   = 1'($urandom);
                in_data   = 8'($urandom);
                out_ready = 1'($urandom);
                tick();
            end
            in_valid  = 1'b1;
            in_data   = frame_q[i];
            in_last   = (i == n - 1);
            out_ready = 1'($urandom);
            check({tag, " beat rdy"}, {rdy_u, rdy_s, vld_u, vld_s}, 4'b1100);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
        model(1'b0, mu, iu, lu, ou);
        model(1'b1, ms, is, ls, os);
        for (int h = 0; h <= hold; h++) begin
            check({tag, " vld/rdy"}, {vld_u, vld_s, rdy_u, rdy_s}, 4'b1100);
            check({tag, " u result"}, {max_u, idx_u, len_u, ovf_u}, {mu, iu, lu, ou});
            check({tag, " s result"}, {max_s, idx_s, len_s, ovf_s}, {ms, is, ls, os});
            out_ready = 1'b0;
            if (h < hold) tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " release"}, {vld_u, vld_s, rdy_u, rdy_s}, 4'b0011);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (3) tick();
        check_reset_state("reset");
        rst = 1'b0;
        tick();

        frame_q = '{8'd3, 8'd9, 8'd9, 8'd2};
        run_frame("t1 3992", 0, 1'b0);

        frame_q = '{8'h55};
        run_frame("t2 single", 2, 1'b0);

        frame_q = '{8'hF0, 8'h80, 8'h05};
        run_frame("t3 sign", 0, 1'b0);
        check("t3 u max", max_u, 8'hF0);
        check("t3 s max", max_s, 8'h05);

        frame_q = {};
        for (int i = 0; i < 18; i++) frame_q.push_back((i == 16) ? 8'hFF : 8'($urandom_range(0, 8'h70)));
        run_frame("t4 ovf", 0, 1'b0);
        check("t4 ff not max", {max_u == 8'hFF, max_s == 8'hFF}, 2'b00);

        frame_q = '{8'd7, 8'd200, 8'd100};
        run_frame("t5 hold", 5, 1'b0);

        // Abort a frame part-way through with reset.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hE0 + 8'(i);
            in_last  = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        check_reset_state("t6 rst");
        rst = 1'b0;
        tick();
        frame_q = '{8'd1, 8'd2};
        run_frame("t6 after", 0, 1'b0);

        for (int f = 0; f < 30; f++) begin
            int n;
            n = $urandom_range(1, 20);
            frame_q = {};
            for (int i = 0; i < n; i++) begin
                // Narrow value range now and then to force ties.
                frame_q.push_back((f % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom));
            end
            run_frame("rand", $urandom_range(0, 3), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
